data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Load/store unit between the single-cycle CPU datapath and the handshake data
//  memory (rden/wren strobes, memory_response pulse, word-indexed array).
//  Converts byte addresses to word indices, extracts and extends byte and halfword
//  loads, and performs read-modify-write for SB/SH. Stalls the CPU until the access
//  completes. Flags misaligned, out-of-range and timed-out accesses.
// PARAMETERS
//  WORD_ADDR_BITS  10  memory depth = 2**WORD_ADDR_BITS words; word index = cpu_addr[WORD_ADDR_BITS+1:2]
//  TIMEOUT_CYCLES  16  wait-state cycles without memory_response before abort (>=2)
// PORTS
//  clk               in   1   single clock, rising edge
//  rst_n             in   1   asynchronous, active-low reset
//  cpu_req           in   1   access request; held stable by CPU while cpu_stall=1
//  cpu_we            in   1   1=store, 0=load
//  cpu_size          in   2   00=byte, 01=half, 10=word, 11=illegal
//  cpu_signed        in   1   loads: 1=sign-extend, 0=zero-extend
//  cpu_addr          in   32  byte address
//  cpu_wdata         in   32  store data (low 8/16 bits used for byte/half)
//  cpu_rdata         out  32  load result, valid while cpu_done=1, held until next accept
//  cpu_stall         out  1   freeze CPU PC/registers
//  cpu_done          out  1   one-cycle completion pulse
//  cpu_err           out  1   one-cycle error pulse (replaces cpu_done)
//  memory_addr       out  32  word index, zero-extended
//  memory_rden       out  1   read strobe, registered
//  memory_wren       out  1   write strobe, registered
//  memory_write_val  out  32  write data, registered
//  memory_read_val   in   32  read data, valid when memory_response=1
//  memory_response   in   1   access-complete pulse
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0 except cpu_stall = combinational
//    term below (0 while rst_n=0); latched request and timeout counter cleared. Reset
//    mid-access drops the request and deasserts strobes immediately; no write issued.
//  - States: IDLE, RD, WR, RMW_RD, GAP, RMW_WR, DONE, ERR.
//  - cpu_stall = (IDLE & cpu_req) | state in {RD,WR,RMW_RD,GAP,RMW_WR}. Low in DONE/ERR.
//  - IDLE & cpu_req: latch we/size/signed/addr/wdata. Check, in order:
//    size=11, or misaligned (half: addr[0]!=0; word: addr[1:0]!=0), or
//    cpu_addr[31:WORD_ADDR_BITS+2]!=0 -> ERR, no strobe.
//    Else load -> RD; store word -> WR; store byte/half -> RMW_RD.
//  - RD/RMW_RD: memory_rden=1; WR/RMW_WR: memory_wren=1, memory_write_val = data.
//    memory_addr driven for the whole access. Exactly one strobe high at a time.
//  - memory_response sampled 1 in a wait state: strobe is 0 from the next cycle;
//    RD -> DONE, WR/RMW_WR -> DONE, RMW_RD -> GAP (captures read word).
//    GAP: one cycle with both strobes 0 (memory returns to ready), then RMW_WR.
//  - Merge (little-endian): byte lane addr[1:0], byte0 = bits[7:0]; half lane addr[1].
//    Unselected lanes keep the read word.
//  - Load result: word as-is; byte/half lane shifted to bit 0, then sign- or
//    zero-extended per latched cpu_signed.
//  - Timeout: counter cleared on entering each wait state, +1 per cycle without
//    response; reaching TIMEOUT_CYCLES -> ERR, strobe dropped. Timeout in RMW_RD
//    means no write is issued.
//  - DONE: cpu_done=1 for one cycle -> IDLE. ERR: cpu_err=1 for one cycle, cpu_rdata
//    unchanged -> IDLE. A new request can be accepted in the cycle after DONE/ERR.
//  - memory_response outside a wait state (IDLE, GAP, DONE, ERR) is ignored.
//  - cpu_req changes while busy are ignored; the latched request is used.
//  - Latency with a 1-cycle-response memory: LW/SW accept->cpu_done = 3 cycles;
//    SB/SH = 6 cycles.
// TESTING
//  1. mem[5]=0x8899AABB; LW addr 0x14 -> rden pulse, memory_addr=5, cpu_rdata=0x8899AABB,
//     cpu_done at accept+3 cycles, stall high until then.
//  2. Same word; LB signed addr 0x17 -> 0xFFFFFF88; LBU addr 0x15 -> 0x000000AA;
//     LH signed addr 0x14 -> 0xFFFFAABB.
//  3. mem[5]=0x8899AABB; SB wdata=0x12 addr 0x16 -> one read, >=1 idle gap cycle,
//     one write of 0x8812AABB. SH addr 0x14 wdata=0x3456 -> 0x88993456.
//  4. LW addr 0x13 -> cpu_err next cycle, no strobe. SH addr 0x15 -> err, memory unchanged.
//     LW addr 0x1000 (WORD_ADDR_BITS=10) -> err, no strobe.
//  5. Memory model never responds to rden -> strobe held 16 cycles, then cpu_err pulse,
//     strobe low. Same with SB: no wren ever seen.
//  6. rst_n low during WR wait and during GAP -> outputs 0 immediately, IDLE after
//     release, memory word unchanged; a following LW completes normally.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Load/store unit: byte-addressed CPU accesses -> word-indexed handshake memory,
// with sub-word load extraction, read-modify-write stores, stall and error reporting.
module data_mem_ctrl #(
    parameter int unsigned WORD_ADDR_BITS = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] memory_addr,
    output logic        memory_rden,
    output logic        memory_wren,
    output logic [31:0] memory_write_val,
    input  logic [31:0] memory_read_val,
    input  logic        memory_response
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = WORD_ADDR_BITS + 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RD, WR, RMW_RD, GAP, RMW_WR, DONE, ERR
    } state_t;

    state_t          state, state_next;
    logic            we_q;
    logic [1:0]      size_q;
    logic            signed_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rmw_q;
    logic [CW-1:0]   tcnt;

    logic            req_bad;
    logic            wait_st;
    logic            timeout;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_val;
    logic [31:0]     merge_val;
    logic [31:0]     wval_next;

    assign wait_st = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);
    assign timeout = (tcnt == CW'(TIMEOUT_CYCLES - 1));

    assign cpu_stall   = rst_n & (((state == IDLE) & cpu_req) | wait_st | (state == GAP));
    assign cpu_done    = (state == DONE);
    assign cpu_err     = (state == ERR);
    assign memory_addr = 32'(addr_q[AW-1:2]);

    // Request legality: illegal size, misalignment, or address beyond memory depth
    always_comb begin
        req_bad = (cpu_size == 2'b11)
               || ((cpu_size == SZ_HALF) && cpu_addr[0])
               || ((cpu_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00))
               || (cpu_addr[31:AW] != '0);
    end

    // Load extraction and store merge from the returned word, using the latched request
    always_comb begin
        byte_sel  = memory_read_val[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = addr_q[1] ? memory_read_val[31:16] : memory_read_val[15:0];
        load_val  = memory_read_val;
        merge_val = memory_read_val;
        case (size_q)
            SZ_BYTE: begin
                load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
                merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_HALF: begin
                load_val = {{16{signed_q & half_sel[15]}}, half_sel};
                merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // Next-state logic and write data for the state being entered
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (req_bad)               state_next = ERR;
                    else if (!cpu_we)          state_next = RD;
                    else if (cpu_size == SZ_WORD) state_next = WR;
                    else                       state_next = RMW_RD;
                end
            end
            RD, WR, RMW_WR: begin
                if (memory_response)  state_next = DONE;
                else if (timeout)     state_next = ERR;
            end
            RMW_RD: begin
                if (memory_response)  state_next = GAP;
                else if (timeout)     state_next = ERR;
            end
            GAP:     state_next = RMW_WR;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        wval_next = '0;
        if (state_next == WR)
            wval_next = (state == IDLE) ? cpu_wdata : wdata_q;
        else if (state_next == RMW_WR)
            wval_next = rmw_q;
    end

    // State, latched request, timeout counter, registered strobes and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            we_q             <= 1'b0;
            size_q           <= '0;
            signed_q         <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            rmw_q            <= '0;
            tcnt             <= '0;
            cpu_rdata        <= '0;
            memory_rden      <= 1'b0;
            memory_wren      <= 1'b0;
            memory_write_val <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && cpu_req) begin
                we_q     <= cpu_we;
                size_q   <= cpu_size;
                signed_q <= cpu_signed;
                addr_q   <= cpu_addr[AW-1:0];
                wdata_q  <= cpu_wdata;
            end
            if (state_next != state)
                tcnt <= '0;
            else if (wait_st)
                tcnt <= tcnt + CW'(1);
            if ((state == RD) && memory_response)
                cpu_rdata <= load_val;
            if ((state == RMW_RD) && memory_response)
                rmw_q <= merge_val;
            memory_rden      <= (state_next == RD) || (state_next == RMW_RD);
            memory_wren      <= (state_next == WR) || (state_next == RMW_WR);
            memory_write_val <= wval_next;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl with a 1-cycle-response memory model.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] memory_addr;
    logic        memory_rden;
    logic        memory_wren;
    logic [31:0] memory_write_val;
    logic [31:0] memory_read_val;
    logic        memory_response;

    data_mem_ctrl #(.WORD_ADDR_BITS(10), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .memory_addr(memory_addr), .memory_rden(memory_rden), .memory_wren(memory_wren),
        .memory_write_val(memory_write_val), .memory_read_val(memory_read_val),
        .memory_response(memory_response)
    );

    always #5 clk = ~clk;

    // Memory model: responds one cycle after a strobe, with a backdoor preload port
    logic [31:0] mem [1024];
    logic        no_resp = 1'b0;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;
    int          n_reads = 0;
    int          n_writes = 0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (!rst_n) begin
            memory_response <= 1'b0;
            memory_read_val <= '0;
        end else begin
            memory_response <= 1'b0;
            if (!no_resp && (memory_rden || memory_wren) && !memory_response) begin
                memory_response <= 1'b1;
                if (memory_wren) begin
                    mem[memory_addr[9:0]] <= memory_write_val;
                    n_writes <= n_writes + 1;
                end else begin
                    memory_read_val <= mem[memory_addr[9:0]];
                    n_reads <= n_reads + 1;
                end
            end
        end
    end

    logic both_hi = 1'b0;
    always @(negedge clk) if (memory_rden && memory_wren) both_hi <= 1'b1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = '0;
    int          rd_cyc, wr_cyc, gap_cyc;
    int          rd0, wr0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          stall_drop;
        logic        fin;
        logic [31:0] a_seen;
        @(negedge clk);
        e.err = exp_err;
        if (!we && !exp_err) last_rd = exp_rd;
        e.rdata = last_rd;
        sb.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_signed = sg;
        cpu_addr = addr; cpu_wdata = wd;
        #1 check({tag, "/stall_accept"}, 32'(cpu_stall), 32'd1);
        lat = 0; fin = 1'b0; stall_drop = 0; a_seen = '0;
        rd_cyc = 0; wr_cyc = 0; gap_cyc = 0;
        while (!fin && lat < 64) begin
            @(negedge clk);
            lat++;
            if (cpu_done || cpu_err) begin
                fin = 1'b1;
            end else begin
                if (memory_rden) rd_cyc++;
                if (memory_wren) wr_cyc++;
                if (!memory_rden && !memory_wren) gap_cyc++;
                if (!cpu_stall) stall_drop++;
                if (memory_rden || memory_wren) a_seen = memory_addr;
            end
        end
        check({tag, "/completed"}, 32'(fin), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/stall_busy_drops"}, 32'(stall_drop), 32'd0);
        check({tag, "/stall_at_end"}, 32'(cpu_stall), 32'd0);
        if (!exp_err) check({tag, "/mem_addr"}, a_seen, {2'b00, addr[31:2]});
        if (fin) begin
            got = sb.pop_front();
            check({tag, "/err"}, 32'(cpu_err), 32'(got.err));
            check({tag, "/done"}, 32'(cpu_done), 32'(!got.err));
            check({tag, "/rdata"}, cpu_rdata, got.rdata);
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_signed = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset/stall", 32'(cpu_stall), 32'd0);
        check("reset/done_err", {30'd0, cpu_done, cpu_err}, 32'd0);
        check("reset/strobes", {30'd0, memory_rden, memory_wren}, 32'd0);
        check("reset/rdata", cpu_rdata, 32'd0);
        check("reset/addr", memory_addr, 32'd0);
        check("reset/wval", memory_write_val, 32'd0);
        cpu_req = 1'b0;
        rst_n = 1'b1;

        // Word and sub-word loads
        poke(10'd5, 32'h8899AABB);
        rd0 = n_reads;
        access("lw_0x14", 1'b0, 2'b10, 1'b0, 32'h14, '0, 1'b0, 32'h8899AABB, 3);
        check("lw_0x14/rden_cycles", 32'(rd_cyc), 32'd2);
        check("lw_0x14/reads", 32'(n_reads - rd0), 32'd1);
        access("lb_0x17", 1'b0, 2'b00, 1'b1, 32'h17, '0, 1'b0, 32'hFFFFFF88, 3);
        access("lbu_0x15", 1'b0, 2'b00, 1'b0, 32'h15, '0, 1'b0, 32'h000000AA, 3);
        access("lh_0x14", 1'b0, 2'b01, 1'b1, 32'h14, '0, 1'b0, 32'hFFFFAABB, 3);
        access("lhu_0x16", 1'b0, 2'b01, 1'b0, 32'h16, '0, 1'b0, 32'h00008899, 3);
        access("lb_0x14", 1'b0, 2'b00, 1'b1, 32'h14, '0, 1'b0, 32'hFFFFFFBB, 3);

        // Read-modify-write stores and a full-word store
        rd0 = n_reads; wr0 = n_writes;
        access("sb_0x16", 1'b1, 2'b00, 1'b0, 32'h16, 32'hFFFFFF12, 1'b0, '0, 6);
        check("sb_0x16/rd_wr_gap", {8'd0, 8'(rd_cyc), 8'(wr_cyc), 8'(gap_cyc)}, 32'h00020201);
        check("sb_0x16/ops", {16'(n_reads - rd0), 16'(n_writes - wr0)}, 32'h00010001);
        check("sb_0x16/mem", mem[5], 32'h8812AABB);
        poke(10'd5, 32'h8899AABB);
        access("sh_0x14", 1'b1, 2'b01, 1'b0, 32'h14, 32'hABCD3456, 1'b0, '0, 6);
        check("sh_0x14/mem", mem[5], 32'h88993456);
        access("sw_0x30", 1'b1, 2'b10, 1'b0, 32'h30, 32'hDEADBEEF, 1'b0, '0, 3);
        check("sw_0x30/mem", mem[12], 32'hDEADBEEF);
        access("lw_0x30", 1'b0, 2'b10, 1'b0, 32'h30, '0, 1'b0, 32'hDEADBEEF, 3);

        // Rejected requests: no strobe, memory untouched, rdata held
        wr0 = n_writes; rd0 = n_reads;
        access("lw_mis_0x13", 1'b0, 2'b10, 1'b0, 32'h13, '0, 1'b1, '0, 1);
        access("sh_mis_0x15", 1'b1, 2'b01, 1'b0, 32'h15, 32'h5555, 1'b1, '0, 1);
        access("lw_oor_0x1000", 1'b0, 2'b10, 1'b0, 32'h1000, '0, 1'b1, '0, 1);
        access("size11", 1'b0, 2'b11, 1'b0, 32'h14, '0, 1'b1, '0, 1);
        check("rejected/no_ops", {16'(n_reads - rd0), 16'(n_writes - wr0)}, 32'd0);
        check("rejected/mem5", mem[5], 32'h88993456);

        // Memory never responds: abort after the timeout
        no_resp = 1'b1;
        access("lw_timeout", 1'b0, 2'b10, 1'b0, 32'h14, '0, 1'b1, '0, 17);
        check("lw_timeout/rden_cycles", 32'(rd_cyc), 32'd16);
        check("lw_timeout/rden_after", 32'(memory_rden), 32'd0);
        wr0 = n_writes;
        access("sb_timeout", 1'b1, 2'b00, 1'b0, 32'h16, 32'h12, 1'b1, '0, 17);
        check("sb_timeout/rw_cycles", {16'(rd_cyc), 16'(wr_cyc)}, {16'd16, 16'd0});
        check("sb_timeout/writes", 32'(n_writes - wr0), 32'd0);
        check("sb_timeout/mem5", mem[5], 32'h88993456);
        no_resp = 1'b0;

        // Reset during the WR wait state
        poke(10'd8, 32'h11111111);
        wr0 = n_writes;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_wr/wren_before", 32'(memory_wren), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_wr/outputs", {28'd0, memory_rden, memory_wren, cpu_stall, cpu_done}, 32'd0);
        cpu_req = 1'b0;
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr/mem8", mem[8], 32'h11111111);
        check("rst_wr/writes", 32'(n_writes - wr0), 32'd0);

        // Reset during the GAP cycle of a byte store
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h21; cpu_wdata = 32'h77;
        repeat (3) @(negedge clk);
        check("rst_gap/in_gap", {29'd0, memory_rden, memory_wren, cpu_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_gap/outputs", {29'd0, memory_rden, memory_wren, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gap/mem8", mem[8], 32'h11111111);
        check("rst_gap/writes", 32'(n_writes - wr0), 32'd0);
        access("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, '0, 1'b0, 32'h11111111, 3);

        check("never_both_strobes", 32'(both_hi), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
